// File: rtl/interp_out_sat_fifo.sv
// Round/saturate FIR interpolator output to OUT_W bits and buffer it for an AXI-Stream master.
// Latency: sample accepted at edge N is presented (m_axis_tvalid=1) after edge N+3 into an empty FIFO.
// Backpressure: input has no ready; a sample arriving at a full FIFO with no transfer is dropped and ovf sticks.
module interp_out_sat_fifo #(
    parameter int IN_W  = 24,
    parameter int OUT_W = 16,
    parameter int SHIFT = 0,
    parameter int ROUND = 1,
    parameter int DEPTH = 16
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic                     s_axis_tvalid,
    input  logic [IN_W-1:0]          s_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic [OUT_W-1:0]         m_axis_tdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic [15:0]              sat_count,
    output logic                     ovf
);

    localparam int AW      = $clog2(DEPTH);
    localparam int TOP_LSB = SHIFT + OUT_W - 1;
    localparam int TOP_W   = IN_W - TOP_LSB + 1;
    localparam int RND_SH  = (SHIFT > 0) ? SHIFT - 1 : 0;

    // Half-LSB of the output window; zero when the window starts at bit 0.
    localparam logic [IN_W:0] RND_ADD =
        (ROUND != 0 && SHIFT > 0) ? ({{IN_W{1'b0}}, 1'b1} << RND_SH) : '0;

    localparam logic [OUT_W-1:0] SAT_POS = {1'b0, {(OUT_W-1){1'b1}}};
    // Symmetric negative clip: most-negative code is never produced by clipping.
    localparam logic [OUT_W-1:0] SAT_NEG = {1'b1, {(OUT_W-2){1'b0}}, 1'b1};

    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);

    // ---------------------------------------------------------------
    // Stage 1: sign-extend and add rounding constant
    // ---------------------------------------------------------------
    logic            r_s1_vld;
    logic [IN_W:0]   r_s1;

    // Register the rounded input one bit wider so the add cannot wrap.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_s1_vld <= 1'b0;
            r_s1     <= '0;
        end else begin
            r_s1_vld <= s_axis_tvalid;
            r_s1     <= {s_axis_tdata[IN_W-1], s_axis_tdata} + RND_ADD;
        end
    end

    // ---------------------------------------------------------------
    // Stage 2: saturate to OUT_W
    // ---------------------------------------------------------------
    logic [TOP_W-1:0] w_top;
    logic [OUT_W-1:0] w_win;
    logic             w_in_range;
    logic             w_clip;
    logic [OUT_W-1:0] w_sat_dat;

    assign w_top      = r_s1[IN_W:TOP_LSB];
    assign w_win      = r_s1[TOP_LSB:SHIFT];
    assign w_in_range = (&w_top) | ~(|w_top);
    assign w_clip     = ~w_in_range;

    // Pick the window when every bit above it matches the sign, else clip toward the sign.
    always_comb begin
        w_sat_dat = w_win;
        if (!w_in_range) begin
            if (r_s1[IN_W]) begin
                w_sat_dat = SAT_NEG;
            end else begin
                w_sat_dat = SAT_POS;
            end
        end
    end

    logic             r_s2_vld;
    logic [OUT_W-1:0] r_s2_dat;
    logic [15:0]      r_sat_count;

    // Register the saturated sample; it is offered to the FIFO on the following edge.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_s2_vld <= 1'b0;
            r_s2_dat <= '0;
        end else begin
            r_s2_vld <= r_s1_vld;
            r_s2_dat <= w_sat_dat;
        end
    end

    // Count clipped samples as they enter stage 2, holding at all-ones.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_sat_count <= '0;
        end else if (r_s1_vld && w_clip && (r_sat_count != 16'hFFFF)) begin
            r_sat_count <= r_sat_count + 16'd1;
        end
    end

    // ---------------------------------------------------------------
    // FIFO: memory behind a registered output slot
    // ---------------------------------------------------------------
    // level counts the output slot plus the memory. The memory only holds
    // data while the output slot is valid (apart from the single cycle
    // after the first write into an empty FIFO), so it never needs more
    // than DEPTH entries and level never exceeds DEPTH.
    logic [OUT_W-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             r_out_vld;
    logic [OUT_W-1:0] r_out_dat;
    logic             r_ovf;

    logic [AW:0]      w_mem_cnt;
    logic             w_mem_empty;
    logic [AW:0]      w_level;
    logic             w_full;
    logic             w_xfer;
    logic             w_wr_ok;
    logic             w_drop;
    logic             w_bypass;
    logic             w_mem_wr;
    logic             w_load;

    assign w_mem_cnt   = r_wr_ptr - r_rd_ptr;
    assign w_mem_empty = (r_wr_ptr == r_rd_ptr);
    assign w_level     = w_mem_cnt + {{AW{1'b0}}, r_out_vld};
    assign w_full      = (w_level == LVL_FULL);
    assign w_xfer      = r_out_vld & m_axis_tready;

    // A transfer in the same cycle frees one place, so a full FIFO still accepts.
    assign w_wr_ok  = r_s2_vld & (~w_full | w_xfer);
    assign w_drop   = r_s2_vld & w_full & ~w_xfer;

    // Last word leaving while a new one arrives: hand it straight to the output
    // slot so tvalid does not bubble. An idle output slot is instead refilled
    // from memory, which keeps the empty-FIFO latency at one extra edge.
    assign w_bypass = w_wr_ok & w_xfer & w_mem_empty;
    assign w_mem_wr = w_wr_ok & ~w_bypass;
    assign w_load   = (~r_out_vld | w_xfer) & ~w_mem_empty;

    // Storage array; contents need no reset since the pointers qualify them.
    always_ff @(posedge aclk) begin
        if (w_mem_wr) begin
            r_mem[r_wr_ptr[AW-1:0]] <= r_s2_dat;
        end
    end

    // Advance write/read pointers; the extra MSB separates full from empty.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_mem_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_load) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

    // Output slot: refill from memory or bypass, clear valid on a final transfer, hold data otherwise.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_out_vld <= 1'b0;
            r_out_dat <= '0;
        end else if (w_load) begin
            r_out_vld <= 1'b1;
            r_out_dat <= r_mem[r_rd_ptr[AW-1:0]];
        end else if (w_bypass) begin
            r_out_vld <= 1'b1;
            r_out_dat <= r_s2_dat;
        end else if (w_xfer) begin
            r_out_vld <= 1'b0;
        end
    end

    // Sticky drop flag, cleared only by reset.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end
    end

    assign m_axis_tvalid = r_out_vld;
    assign m_axis_tdata  = r_out_dat;
    assign level         = w_level;
    assign sat_count     = r_sat_count;
    assign ovf           = r_ovf;

endmodule
